// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and GF(256) helpers for the AES key
// schedule engine.
//   state_e      : engine FSM states (IDLE, EMIT)
//   NR_AES128    : number of rounds for AES-128
//   RCON_LAST    : round constant of the last forward step (first inverse step)
//   RCON_FIRST   : round constant of the first forward step
//   xtime        : GF(256) multiply by 2
//   gfmul_8d     : GF(256) multiply by 0x8d (inverse of xtime)
//   gf_mul       : general GF(256) multiply (used by the S-box inverter)
//   rot_word     : AES RotWord
//   sbox_affine  : AES S-box affine transform
package aes_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int         NR_AES128  = 10;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam logic [7:0] RCON_FIRST = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // 0x8d = 0x80 ^ 0x08 ^ 0x04 ^ 0x01, so build the product from powers of 2.
  function automatic logic [7:0] gfmul_8d(input logic [7:0] x);
    logic [7:0] p [8];
    p[0] = x;
    for (int i = 1; i < 8; i++) begin
      p[i] = xtime(p[i-1]);
    end
    return p[7] ^ p[3] ^ p[2] ^ p[0];
  endfunction

  // Shift-and-add multiply; the mask form keeps the loop branch free.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (sh & {8{b[i]}});
      sh  = xtime(sh);
    end
    return acc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // b = a ^ rotl(a,1) ^ rotl(a,2) ^ rotl(a,3) ^ rotl(a,4) ^ 0x63
  function automatic logic [7:0] sbox_affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
//   in_byte  : input byte
//   out_byte : S(in_byte)
// Computed as the multiplicative inverse (x^254, with 0 -> 0) followed by
// the affine transform, instead of a 256-entry table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] inv_s;

  // x^254 = x^2 * x^4 * ... * x^128 via repeated squaring.
  always_comb begin
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = in_byte;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    inv_s = acc;
  end

  assign out_byte = sbox_affine(inv_s);

endmodule

// File: rtl/aes_inv_keyexp.sv
// aes_inv_keyexp: sequential AES-128 inverse key schedule. Takes the
// round-10 key and emits round keys 10..0, one per rk handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : key_in handshake (in_ready high only when idle)
//   key_in            : round-10 key, w[40] in [127:96]
//   rk_valid/rk_ready : round-key handshake, stable under backpressure
//   rk_data           : current round key
//   rk_round          : round index of rk_data
//   rk_last           : marks the final key of the sequence
// Optional build macro AES_INVKEY_FWD_EN adds input 'dir' (sampled at key
// accept): dir=1 inverse schedule, dir=0 forward schedule from the round-0
// key with rk_round counting 0..10.
module aes_inv_keyexp
  import aes_pkg::*;
#(
  parameter int         NR        = NR_AES128,
  parameter logic [7:0] RCON_INIT = RCON_LAST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
`ifdef AES_INVKEY_FWD_EN
  input  logic         dir,
`endif
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  localparam logic [3:0] ROUND_MAX = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic         in_ready_q, in_ready_d;
  logic         rk_valid_q, rk_valid_d;
  logic         rk_last_q, rk_last_d;

  logic         fwd_s;       // direction of the running sequence
  logic         fwd_in_s;    // direction requested with key_in
  logic         fwd_nxt_s;   // direction after this clock edge
  logic         accept_s;
  logic [3:0]   end_round_s;
  logic [3:0]   end_round_nxt_s;

  assign accept_s = in_valid && in_ready_q;

`ifdef AES_INVKEY_FWD_EN
  logic dir_q, dir_d;

  // Latch the requested direction only when a key is taken.
  always_comb begin
    if ((state_q == IDLE) && accept_s) begin
      dir_d = dir;
    end else begin
      dir_d = dir_q;
    end
  end

  // Direction register; reset selects the inverse schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b1;
    end else begin
      dir_q <= dir_d;
    end
  end

  assign fwd_s     = ~dir_q;
  assign fwd_in_s  = ~dir;
  assign fwd_nxt_s = ~dir_d;
`else
  assign fwd_s     = 1'b0;
  assign fwd_in_s  = 1'b0;
  assign fwd_nxt_s = 1'b0;
`endif

  assign end_round_s     = fwd_s     ? ROUND_MAX : 4'd0;
  assign end_round_nxt_s = fwd_nxt_s ? ROUND_MAX : 4'd0;

  // ---------------------------------------------------------------------
  // One key-schedule step. Both directions share a single SubWord: the
  // inverse step feeds the freshly derived n3, the forward step feeds k3.
  // ---------------------------------------------------------------------
  logic [31:0]  k0_s, k1_s, k2_s, k3_s;
  logic [31:0]  inv_n3_s;
  logic [31:0]  rot_s, sub_s;
  logic [127:0] key_step_s;

  assign k0_s     = key_q[127:96];
  assign k1_s     = key_q[95:64];
  assign k2_s     = key_q[63:32];
  assign k3_s     = key_q[31:0];
  assign inv_n3_s = k3_s ^ k2_s;
  assign rot_s    = rot_word(fwd_s ? k3_s : inv_n3_s);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_s[8*g +: 8]),
      .out_byte (sub_s[8*g +: 8])
    );
  end

  // Next round key in the active direction.
  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    if (fwd_s) begin
      n0 = k0_s ^ sub_s ^ {rcon_q, 24'h000000};
      n1 = k1_s ^ n0;
      n2 = k2_s ^ n1;
      n3 = k3_s ^ n2;
    end else begin
      n3 = inv_n3_s;
      n2 = k2_s ^ k1_s;
      n1 = k1_s ^ k0_s;
      n0 = k0_s ^ sub_s ^ {rcon_q, 24'h000000};
    end
    key_step_s = {n0, n1, n2, n3};
  end

  // FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EMIT;
          key_d   = key_in;
          rcon_d  = fwd_in_s ? RCON_FIRST : RCON_INIT;
          round_d = fwd_in_s ? 4'd0 : ROUND_MAX;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q == end_round_s) begin
            // Final beat: keep the key so rk_data does not glitch.
            state_d = IDLE;
          end else begin
            key_d   = key_step_s;
            rcon_d  = fwd_s ? xtime(rcon_q) : gfmul_8d(rcon_q);
            round_d = fwd_s ? (round_q + 4'd1) : (round_q - 4'd1);
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs follow the next state so they can be registered.
  always_comb begin
    in_ready_d = (state_d == IDLE);
    rk_valid_d = (state_d == EMIT);
    rk_last_d  = (state_d == EMIT) && (round_d == end_round_nxt_s);
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= 128'h0;
      rcon_q     <= 8'h00;
      round_q    <= 4'd0;
      in_ready_q <= 1'b1;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      rcon_q     <= rcon_d;
      round_q    <= round_d;
      in_ready_q <= in_ready_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
    end
  end

  assign in_ready = in_ready_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = key_q;
  assign rk_round = round_q;
  assign rk_last  = rk_last_q;

endmodule

// File: tb/tb_aes_inv_keyexp.sv
// tb_aes_inv_keyexp: randomized self-checking bench for aes_inv_keyexp.
// Reference is a FIPS-197 style word-array key expansion (w[0..43]) run
// backwards or forwards, with an S-box table generated by the log/antilog
// walk over GF(256).
module tb_aes_inv_keyexp;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key_in = 128'h0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
`ifdef AES_INVKEY_FWD_EN
  logic         dir = 1'b1;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   rcon_t  [1:10];
  logic [127:0] exp_rk  [11];
  int           exp_rnd [11];
  logic         exp_lst [11];
  logic [7:0]   exp_rc  [11];
  logic [127:0] cap_rk  [11];

  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_inv_keyexp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key_in   (key_in),
`ifdef AES_INVKEY_FWD_EN
    .dir      (dir),
`endif
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .rk_last  (rk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
    n_vec++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, req);
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  task automatic init_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sbox_t[p] = x;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    rcon_t[1] = 8'h01;
    for (int j = 2; j <= 10; j++) begin
      rcon_t[j] = {rcon_t[j-1][6:0], 1'b0} ^ (rcon_t[j-1][7] ? 8'h1b : 8'h00);
    end
  endtask

  // Expected beats in emission order for one key.
  task automatic build_model(input logic [127:0] key, input bit fwd);
    logic [31:0] w [44];
    logic [31:0] t;
    if (fwd) begin
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
        t = w[i-1];
        if (i % 4 == 0) t = sub_rot(t) ^ {rcon_t[i/4], 24'h0};
        w[i] = w[i-4] ^ t;
      end
    end else begin
      for (int i = 0; i < 4; i++) w[40+i] = key[127-32*i -: 32];
      for (int i = 39; i >= 0; i--) begin
        t = w[i+3];
        if (i % 4 == 0) t = sub_rot(t) ^ {rcon_t[i/4+1], 24'h0};
        w[i] = w[i+4] ^ t;
      end
    end
    for (int b = 0; b < 11; b++) begin
      int r;
      r = fwd ? b : 10 - b;
      exp_rnd[b] = r;
      exp_rk[b]  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_lst[b] = (b == 10);
      exp_rc[b]  = (b < 10) ? (fwd ? rcon_t[b+1] : rcon_t[10-b]) : 8'h00;
    end
  endtask

  // Present a key at a negedge; return at the negedge after acceptance.
  task automatic issue(input logic [127:0] k, input bit fwd);
    int cyc;
    key_in   = k;
    in_valid = 1'b1;
`ifdef AES_INVKEY_FWD_EN
    dir = ~fwd;
`endif
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consume nbeats round keys; mode 0 = always ready, 1 = random stalls.
  task automatic collect(input int mode, input int nbeats);
    int b, cyc;
    bit stalled;
    logic [127:0] prev_d;
    logic [3:0] prev_r;
    b = 0;
    cyc = 0;
    stalled = 1'b0;
    while (b < nbeats && cyc < 400) begin
      chk("rk_valid", 128'(rk_valid), 128'(1));
      if (!rk_valid) break;
      chk("rk_data", rk_data, exp_rk[b]);
      chk("rk_round", 128'(rk_round), 128'(exp_rnd[b]));
      chk("rk_last", 128'(rk_last), 128'(exp_lst[b]));
      chk("in_ready_busy", 128'(in_ready), 128'(0));
      if (b < 10) chk("rcon", 128'(dut.rcon_q), 128'(exp_rc[b]));
      if (stalled) begin
        chk("hold_data", rk_data, prev_d);
        chk("hold_round", 128'(rk_round), 128'(prev_r));
      end
      rk_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
      stalled  = !rk_ready;
      prev_d   = rk_data;
      prev_r   = rk_round;
      if (rk_ready) cap_rk[b] = rk_data;
      @(negedge clk);
      cyc++;
      if (!stalled) b++;
    end
    rk_ready = 1'b0;
    chk("beats_done", 128'(b), 128'(nbeats));
    if (nbeats == 11) begin
      chk("in_ready_after", 128'(in_ready), 128'(1));
      chk("rk_valid_after", 128'(rk_valid), 128'(0));
    end
  endtask

  initial begin
    logic [127:0] ka, kb;
    init_tables();

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_rk_valid", 128'(rk_valid), 128'(0));
    chk("rst_rk_data", rk_data, 128'h0);
    chk("rst_rk_round", 128'(rk_round), 128'(0));
    chk("rst_rk_last", 128'(rk_last), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer sequence, no backpressure.
    build_model(K10, 1'b0);
    issue(K10, 1'b0);
    collect(0, 11);
    chk("fips_beat0", cap_rk[0], K10);
    chk("fips_beat1", cap_rk[1], K9);
    chk("fips_beat10", cap_rk[10], K0);

    // Same key under random backpressure.
    issue(K10, 1'b0);
    collect(1, 11);
    chk("bp_beat10", cap_rk[10], K0);

    // Second key held during EMIT: taken only after the round-0 handshake.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    build_model(ka, 1'b0);
    issue(ka, 1'b0);
    key_in   = kb;
    in_valid = 1'b1;
    collect(0, 11);
    build_model(kb, 1'b0);
    issue(kb, 1'b0);
    collect(0, 11);

    // Random keys with random stalls.
    for (int n = 0; n < 6; n++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      build_model(ka, 1'b0);
      issue(ka, 1'b0);
      collect(1, 11);
    end

    // Reset after the round-6 beat, then restart cleanly.
    ka = {$urandom, $urandom, $urandom, $urandom};
    build_model(ka, 1'b0);
    issue(ka, 1'b0);
    collect(0, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_rk_valid", 128'(rk_valid), 128'(0));
    chk("mid_rst_rk_data", rk_data, 128'h0);
    chk("mid_rst_rk_round", 128'(rk_round), 128'(0));
    chk("mid_rst_rk_last", 128'(rk_last), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kb = {$urandom, $urandom, $urandom, $urandom};
    build_model(kb, 1'b0);
    issue(kb, 1'b0);
    collect(1, 11);

`ifdef AES_INVKEY_FWD_EN
    // Forward direction from the round-0 key.
    build_model(K0, 1'b1);
    issue(K0, 1'b1);
    collect(0, 11);
    chk("fwd_beat10", cap_rk[10], K10);
    ka = {$urandom, $urandom, $urandom, $urandom};
    build_model(ka, 1'b1);
    issue(ka, 1'b1);
    collect(1, 11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
